// File: rtl/fifo_stream_pkg.sv
// Shared constants and helpers for the FIFO read-side stream drain.
// Holds default geometry, stats counter width and a clog2 helper.
package fifo_stream_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_BUF_DEPTH = 3;
    localparam int STATS_W       = 32;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// Circular prefetch buffer: storage, read/write pointers and occupancy.
// Push, pop and flush are single-cycle; flush wins over push and pop.
module stream_buf
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_BUF_DEPTH
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_data,
    input  logic                           i_pop,
    input  logic                           i_flush,
    output logic [clog2(DEPTH+1)-1:0]      o_cnt,
    output logic                           o_valid,
    output logic [WIDTH-1:0]               o_data
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    // Non power-of-two depths need an explicit wrap compare.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push  = i_push & ~i_flush;
    assign w_pop   = i_pop & (r_cnt != '0) & ~i_flush;
    assign o_cnt   = r_cnt;
    assign o_valid = (r_cnt != '0);
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= nxt(r_wr);
            end
            if (w_pop) begin
                r_rd <= nxt(r_rd);
            end
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    a_cnt_range: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        r_cnt <= CW'(DEPTH)
    );

    a_no_overflow: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        !(w_push && !w_pop && r_cnt == CW'(DEPTH))
    );

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain drain of the dual-clock FIFO into a valid/ready stream.
// Optional FIFO_RD_STREAM_STATS_EN adds rd_words / stall_cycles counters.
module fifo_rd_stream
    import fifo_stream_pkg::*;
#(
    parameter int width     = DEF_WIDTH,
    parameter int buf_depth = DEF_BUF_DEPTH
) (
    input  logic               rclk,
    input  logic               rrst_n,
    input  logic               fifo_empty,
    input  logic [width-1:0]   fifo_rdata,
    output logic               fifo_r_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [width-1:0]   out_data,
    input  logic               flush
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [STATS_W-1:0] rd_words,
    output logic [STATS_W-1:0] stall_cycles
`endif
);

    localparam int CW = clog2(buf_depth + 1);

    logic [CW-1:0] w_cnt;
    logic [CW:0]   w_used;
    logic          w_credit;
    logic          w_pop;
    logic          r_pend;

    // Credit counts the word still in flight so cnt can never overflow.
    assign w_used    = {1'b0, w_cnt} + {{CW{1'b0}}, r_pend};
    assign w_credit  = (w_used < (CW+1)'(buf_depth));
    assign fifo_r_en = rrst_n & ~fifo_empty & ~flush & w_credit;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= fifo_r_en;
        end
    end

    stream_buf #(
        .WIDTH (width),
        .DEPTH (buf_depth)
    ) u_buf (
        .i_clk   (rclk),
        .i_rst_n (rrst_n),
        .i_push  (r_pend),
        .i_data  (fifo_rdata),
        .i_pop   (w_pop),
        .i_flush (flush),
        .o_cnt   (w_cnt),
        .o_valid (out_valid),
        .o_data  (out_data)
    );

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [STATS_W-1:0] r_words;
    logic [STATS_W-1:0] r_stall;

    // Word count wraps; stall count saturates.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_words <= '0;
            r_stall <= '0;
        end else begin
            if (w_pop) begin
                r_words <= r_words + 1'b1;
            end
            if (out_valid && !out_ready && !(&r_stall)) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    assign rd_words     = r_words;
    assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: vector table plus multi-cycle sequences.
// Covers depth 3 and depth 2 instances; stats checks with FIFO_RD_STREAM_STATS_EN.
module tb_fifo_rd_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic use_model;

    logic       t_empty;
    logic [7:0] t_rdata;

    logic       a_empty, a_ren, a_valid, a_ready, a_flush;
    logic [7:0] a_rdata, a_data;
    logic       b_empty, b_ren, b_valid, b_ready;
    logic [7:0] b_rdata, b_data;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] a_words, a_stall, b_words, b_stall;
`endif

    // Behavioural upstream FIFOs: registered rdata, one-cycle latency.
    logic [7:0] ma_mem [64];
    int         ma_head = 0;
    int         ma_tail = 0;
    logic [7:0] ma_rdata = 8'h00;
    logic [7:0] mb_mem [64];
    int         mb_head = 0;
    int         mb_tail = 0;
    logic [7:0] mb_rdata = 8'h00;

    assign a_empty = use_model ? (ma_head == ma_tail) : t_empty;
    assign a_rdata = use_model ? ma_rdata : t_rdata;
    assign b_empty = (mb_head == mb_tail);
    assign b_rdata = mb_rdata;

    always @(posedge clk) begin
        if (use_model && a_ren && !a_empty) begin
            ma_rdata <= ma_mem[ma_head[5:0]];
            ma_head  <= ma_head + 1;
        end
        if (b_ren && !b_empty) begin
            mb_rdata <= mb_mem[mb_head[5:0]];
            mb_head  <= mb_head + 1;
        end
    end

    fifo_rd_stream #(.width(8), .buf_depth(3)) dut_a (
        .rclk       (clk),
        .rrst_n     (rst_n),
        .fifo_empty (a_empty),
        .fifo_rdata (a_rdata),
        .fifo_r_en  (a_ren),
        .out_valid  (a_valid),
        .out_ready  (a_ready),
        .out_data   (a_data),
        .flush      (a_flush)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .rd_words     (a_words),
        .stall_cycles (a_stall)
`endif
    );

    fifo_rd_stream #(.width(8), .buf_depth(2)) dut_b (
        .rclk       (clk),
        .rrst_n     (rst_n),
        .fifo_empty (b_empty),
        .fifo_rdata (b_rdata),
        .fifo_r_en  (b_ren),
        .out_valid  (b_valid),
        .out_ready  (b_ready),
        .out_data   (b_data),
        .flush      (1'b0)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .rd_words     (b_words),
        .stall_cycles (b_stall)
`endif
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic       empty;
        logic [7:0] rdata;
        logic       ready;
        logic       flush;
        logic       e_ren;
        logic       e_valid;
        logic       chk_d;
        logic [7:0] e_data;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic r, input logic e,
                                input logic [7:0] d, input logic rdy,
                                input logic f, input logic xr,
                                input logic xv, input logic cd,
                                input logic [7:0] xd);
        vec_t v;
        v.rst_n = r;   v.empty = e;   v.rdata = d;
        v.ready = rdy; v.flush = f;   v.e_ren = xr;
        v.e_valid = xv; v.chk_d = cd; v.e_data = xd;
        return v;
    endfunction

    task automatic load_a(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            ma_mem[ma_tail[5:0]] = base + 8'(i);
            ma_tail = ma_tail + 1;
        end
    endtask

    task automatic load_b(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            mb_mem[mb_tail[5:0]] = base + 8'(i);
            mb_tail = mb_tail + 1;
        end
    endtask

    // Samples at negedge; a word seen with valid&ready is taken next posedge.
    task automatic collect(input bit sel, input int n, input logic [7:0] base,
                           input string tag, output int span);
        int got, first, last;
        got = 0; first = 0; last = 0;
        for (int c = 0; c < 300 && got < n; c++) begin
            if (sel ? (b_valid && b_ready) : (a_valid && a_ready)) begin
                chk($sformatf("%s word %0d", tag, got),
                    {24'h0, sel ? b_data : a_data}, 32'(base) + 32'(got));
                if (got == 0) first = c;
                last = c;
                got++;
            end
            @(negedge clk);
        end
        chk($sformatf("%s count", tag), got, n);
        span = last - first;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int span, pulses, n;

        rst_n = 1'b0; use_model = 1'b0;
        t_empty = 1'b1; t_rdata = 8'h00;
        a_ready = 1'b0; a_flush = 1'b0; b_ready = 1'b0;

        // reset
        tv.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h00));
        tv.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h00));
        // single word 0xA5
        tv.push_back(mk(1, 0, 8'h00, 1, 0, 1, 0, 0, 8'h00));
        tv.push_back(mk(1, 1, 8'hA5, 1, 0, 0, 0, 0, 8'h00));
        tv.push_back(mk(1, 1, 8'hA5, 1, 0, 0, 1, 1, 8'hA5));
        tv.push_back(mk(1, 1, 8'hA5, 1, 0, 0, 0, 1, 8'h00));
        // flush with cnt=2 and a word in flight
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00));
        tv.push_back(mk(1, 0, 8'h11, 0, 0, 1, 0, 0, 8'h00));
        tv.push_back(mk(1, 0, 8'h22, 0, 0, 1, 1, 1, 8'h11));
        tv.push_back(mk(1, 0, 8'h33, 0, 1, 0, 1, 1, 8'h11));
        tv.push_back(mk(1, 0, 8'h33, 0, 0, 1, 0, 0, 8'h00));
        tv.push_back(mk(1, 1, 8'h44, 0, 0, 0, 0, 0, 8'h00));
        tv.push_back(mk(1, 1, 8'h44, 1, 0, 0, 1, 1, 8'h44));
        tv.push_back(mk(1, 1, 8'h44, 1, 0, 0, 0, 0, 8'h00));
        // reset mid-stream
        tv.push_back(mk(1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00));
        tv.push_back(mk(1, 0, 8'h55, 0, 0, 1, 0, 0, 8'h00));
        tv.push_back(mk(1, 1, 8'h66, 0, 0, 0, 1, 1, 8'h55));
        tv.push_back(mk(0, 0, 8'h66, 0, 0, 0, 1, 1, 8'h55));
        tv.push_back(mk(1, 1, 8'h00, 0, 0, 0, 0, 1, 8'h00));

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            rst_n   = tv[i].rst_n;
            t_empty = tv[i].empty;
            t_rdata = tv[i].rdata;
            a_ready = tv[i].ready;
            a_flush = tv[i].flush;
            #1;
            chk($sformatf("vec%0d r_en", i), a_ren, tv[i].e_ren);
            chk($sformatf("vec%0d valid", i), a_valid, tv[i].e_valid);
            if (tv[i].chk_d) begin
                chk($sformatf("vec%0d data", i), a_data, tv[i].e_data);
            end
        end

        @(negedge clk);
        use_model = 1'b1;
        a_ready = 1'b0;
        a_flush = 1'b0;

`ifdef FIFO_RD_STREAM_STATS_EN
        chk("stats rd_words after reset", a_words, 0);
        chk("stats stall after reset", a_stall, 0);
        load_a(5, 8'h70);
        n = 0;
        while (!a_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stats valid timeout", {31'h0, a_valid}, 1);
        repeat (4) @(negedge clk);
        a_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("stats rd_words", a_words, 5);
        chk("stats stall_cycles", a_stall, 4);
        a_ready = 1'b0;
        @(negedge clk);
`endif

        // streaming at full rate, depth 3
        a_ready = 1'b1;
        load_a(20, 8'h00);
        collect(1'b0, 20, 8'h00, "stream3", span);
        chk("stream3 span", span, 19);

        // backpressure: exactly three pops, first word held stable
        a_ready = 1'b0;
        repeat (3) @(negedge clk);
        load_a(6, 8'h30);
        #1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (a_ren) pulses++;
            if (a_valid) begin
                chk($sformatf("bp hold c%0d", c), a_data, 8'h30);
            end
            @(negedge clk);
            #1;
        end
        chk("bp r_en pulses", pulses, 3);
        chk("bp r_en low", a_ren, 0);
        a_ready = 1'b1;
        collect(1'b0, 6, 8'h30, "bp drain", span);

        // depth 2: no loss, at least one word per two cycles, below full rate
        b_ready = 1'b1;
        load_b(20, 8'h80);
        collect(1'b1, 20, 8'h80, "depth2", span);
        chk("depth2 slower than 1/cycle", {31'h0, span >= 20}, 1);
        chk("depth2 at least 1/2 cycles", {31'h0, span <= 38}, 1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
